// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
//   Shared definitions for the multi-cycle RV32I control path:
//   - state_t        : main control FSM states (also exported on state_o)
//   - OPC_*          : RV32I major opcodes (instr[6:0])
//   - IMM_*          : immediate-generator format codes
//   - PC_SEL_*       : PC source select encodings
//   - WB_SEL_*       : register-file writeback source encodings
//   - ALU_OP_*       : ALU operation class encodings
//   - instr_class_t  : coarse instruction class produced by ctrl_decode
//   - decode_t       : ctrl_decode result bundle
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

  // FETCH is encoded as zero so that the forced-to-zero debug output seen
  // while reset is asserted reads back as the state the FSM restarts in.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_I    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
  localparam logic [1:0] PC_SEL_ALU   = 2'b01;
  localparam logic [1:0] PC_SEL_JALR  = 2'b10;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b01;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b10;

  typedef enum logic [3:0] {
    CLS_OP      = 4'd0,
    CLS_OP_IMM  = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_NOP     = 4'd9,   // MISC-MEM / SYSTEM: retire as PC+4
    CLS_ILLEGAL = 4'd10
  } instr_class_t;

  typedef struct packed {
    logic [2:0]   imm_sel;
    instr_class_t cls;
    logic         legal;
  } decode_t;

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
//   Purely combinational opcode decoder. Maps instr[6:0] to the immediate
//   format, the instruction class and a legal flag. Kept free of any FSM
//   state so it can be reused by a pipelined control path later.
//
// Ports:
//   opcode  in   7  instruction bits [6:0]
//   dec     out     decode_t {imm_sel, cls, legal}
// ---------------------------------------------------------------------------
module ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output decode_t    dec
);

  always_comb begin
    dec.imm_sel = IMM_NONE;
    dec.cls     = CLS_ILLEGAL;
    dec.legal   = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.cls = CLS_OP;
      end
      OPC_OP_IMM: begin
        dec.imm_sel = IMM_I;
        dec.cls     = CLS_OP_IMM;
      end
      OPC_LOAD: begin
        dec.imm_sel = IMM_I;
        dec.cls     = CLS_LOAD;
      end
      OPC_JALR: begin
        dec.imm_sel = IMM_I;
        dec.cls     = CLS_JALR;
      end
      OPC_STORE: begin
        dec.imm_sel = IMM_S;
        dec.cls     = CLS_STORE;
      end
      OPC_BRANCH: begin
        dec.imm_sel = IMM_B;
        dec.cls     = CLS_BRANCH;
      end
      OPC_LUI: begin
        dec.imm_sel = IMM_U;
        dec.cls     = CLS_LUI;
      end
      OPC_AUIPC: begin
        dec.imm_sel = IMM_U;
        dec.cls     = CLS_AUIPC;
      end
      OPC_JAL: begin
        dec.imm_sel = IMM_J;
        dec.cls     = CLS_JAL;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        dec.cls = CLS_NOP;
      end
      default: begin
        dec.cls   = CLS_ILLEGAL;
        dec.legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM of the multi-cycle RV32I core:
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, plus a sticky HALT
//   reached on an illegal opcode when ILLEGAL_HALT=1.
//
// Handshakes: a request (imem_req / dmem_req) is held high for as long as the
//   FSM sits in the requesting state; the transfer completes in the cycle the
//   matching ready is high while the request is high. ready is ignored in any
//   state that does not issue the request. Zero-wait (ready in the first
//   request cycle) is legal.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   instr_in[31:0]          instruction register contents (valid from DECODE)
//   imem_req / imem_ready   instruction fetch handshake
//   dmem_req / dmem_ready   data access handshake, dmem_we = 1 for stores
//   br_taken                branch comparator result
//   ir_we, pc_we, pc_sel    instruction register / PC update controls
//   imm_sel                 immediate format (IMM_*)
//   alu_src_a, alu_src_b    0 rs1 / 1 PC ; 0 rs2 / 1 immediate
//   alu_op                  ALU operation class (ALU_OP_*)
//   rf_we, wb_sel           register-file write enable / source
//   illegal                 sticky illegal-instruction flag
//   state_o                 current FSM state (debug)
//
// Every output is forced to zero while rst_n is low, so an access in flight
// is dropped in the very cycle reset is asserted.
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        br_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  imm_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state_o
);

  state_t  state;
  logic    illegal_q;
  decode_t dec;

  // Only the opcode field steers control; the rest of the word feeds the
  // datapath directly.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_in[31:7];

  ctrl_decode u_decode (
    .opcode (instr_in[6:0]),
    .dec    (dec)
  );

  // -------------------------------------------------------------------------
  // State register and sticky illegal flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ready) state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (!dec.legal) begin
            illegal_q <= 1'b1;
            state     <= ILLEGAL_HALT ? ST_HALT : ST_FETCH;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (dec.cls)
            CLS_OP, CLS_OP_IMM, CLS_JAL, CLS_JALR,
            CLS_AUIPC, CLS_LUI:       state <= ST_WB;
            CLS_LOAD, CLS_STORE:      state <= ST_MEM;
            default:                  state <= ST_FETCH;  // branch, NOP
          endcase
        end
        ST_MEM: begin
          if (dmem_ready) state <= (dec.cls == CLS_STORE) ? ST_FETCH : ST_WB;
        end
        ST_WB:   state <= ST_FETCH;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Control outputs. Mealy terms (ir_we, the MEM-exit pc_we, branch pc_sel)
  // follow the same-cycle ready / br_taken inputs.
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PLUS4;
    imm_sel   = IMM_NONE;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_OP_ADD;
    rf_we     = 1'b0;
    wb_sel    = WB_SEL_ALU;
    illegal   = illegal_q;
    state_o   = state;

    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end

      ST_DECODE: begin
        imm_sel   = dec.imm_sel;
        // PC + imm is computed here and held in the ALU result register so
        // a taken branch in EXEC can load it while the ALU compares rs1/rs2.
        alu_src_a = 1'b1;
        alu_src_b = 1'b1;
        alu_op    = ALU_OP_ADD;
        if (!dec.legal && !ILLEGAL_HALT) begin
          pc_we  = 1'b1;
          pc_sel = PC_SEL_PLUS4;
        end
      end

      ST_EXEC: begin
        imm_sel = dec.imm_sel;
        case (dec.cls)
          CLS_OP: begin
            alu_op = ALU_OP_FUNCT;
          end
          CLS_OP_IMM: begin
            alu_op    = ALU_OP_FUNCT;
            alu_src_b = 1'b1;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_op    = ALU_OP_ADD;
            alu_src_b = 1'b1;
          end
          CLS_BRANCH: begin
            alu_op = ALU_OP_BRANCH;
            pc_we  = 1'b1;
            pc_sel = br_taken ? PC_SEL_ALU : PC_SEL_PLUS4;
          end
          CLS_JAL, CLS_AUIPC: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
          end
          CLS_JALR: begin
            alu_src_a = 1'b0;
            alu_src_b = 1'b1;
          end
          CLS_NOP: begin
            pc_we  = 1'b1;
            pc_sel = PC_SEL_PLUS4;
          end
          default: begin
            // LUI needs no ALU work; the immediate is written back directly.
          end
        endcase
      end

      ST_MEM: begin
        imm_sel  = dec.imm_sel;
        dmem_req = 1'b1;
        dmem_we  = (dec.cls == CLS_STORE);
        // A store retires as soon as the access completes.
        if (dmem_ready && dec.cls == CLS_STORE) begin
          pc_we  = 1'b1;
          pc_sel = PC_SEL_PLUS4;
        end
      end

      ST_WB: begin
        imm_sel = dec.imm_sel;
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        case (dec.cls)
          CLS_LOAD:           wb_sel = WB_SEL_LOAD;
          CLS_JAL, CLS_JALR:  wb_sel = WB_SEL_PC4;
          CLS_LUI:            wb_sel = WB_SEL_IMM;
          default:            wb_sel = WB_SEL_ALU;
        endcase
        case (dec.cls)
          CLS_JAL:  pc_sel = PC_SEL_ALU;
          CLS_JALR: pc_sel = PC_SEL_JALR;
          default:  pc_sel = PC_SEL_PLUS4;
        endcase
      end

      default: begin
        // HALT: no enables, no requests until reset.
      end
    endcase

    if (!rst_n) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'b00;
      imm_sel   = 3'b000;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = 2'b00;
      rf_we     = 1'b0;
      wb_sel    = 2'b00;
      illegal   = 1'b0;
      state_o   = 3'b000;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  // shared stimulus
  logic [31:0] instr_in = 32'h0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        br_taken = 1'b0;

  // dut: ILLEGAL_HALT=1
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_src_a, alu_src_b;
  logic       rf_we, illegal;
  logic [1:0] pc_sel, alu_op, wb_sel;
  logic [2:0] imm_sel, state_o;

  // dut_nh: ILLEGAL_HALT=0
  logic       nh_imem_req, nh_dmem_req, nh_dmem_we, nh_ir_we, nh_pc_we;
  logic       nh_alu_src_a, nh_alu_src_b, nh_rf_we, nh_illegal;
  logic [1:0] nh_pc_sel, nh_alu_op, nh_wb_sel;
  logic [2:0] nh_imm_sel, nh_state_o;

  multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .br_taken(br_taken), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal),
    .state_o(state_o)
  );

  multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) dut_nh (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in),
    .imem_req(nh_imem_req), .imem_ready(imem_ready),
    .dmem_req(nh_dmem_req), .dmem_we(nh_dmem_we), .dmem_ready(dmem_ready),
    .br_taken(br_taken), .ir_we(nh_ir_we), .pc_we(nh_pc_we), .pc_sel(nh_pc_sel),
    .imm_sel(nh_imm_sel), .alu_src_a(nh_alu_src_a), .alu_src_b(nh_alu_src_b),
    .alu_op(nh_alu_op), .rf_we(nh_rf_we), .wb_sel(nh_wb_sel), .illegal(nh_illegal),
    .state_o(nh_state_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: expected state trace, counters, snapshot of the last cycle
  // ---------------------------------------------------------------------------
  logic [2:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cnt_rf, cnt_pc, cnt_ir, cnt_dreq;
  string cur;

  logic       s_imem_req, s_dmem_req, s_dmem_we, s_ir_we, s_pc_we;
  logic       s_alu_src_a, s_alu_src_b, s_rf_we, s_illegal;
  logic [1:0] s_pc_sel, s_alu_op, s_wb_sel;
  logic [2:0] s_imm_sel;
  logic [21:0] s_all;
  logic       s_nh_imem_req, s_nh_ir_we, s_nh_pc_we, s_nh_illegal;
  logic [1:0] s_nh_pc_sel;
  logic [2:0] s_nh_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", cur, tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic [2:0] s);
    exp_q.push_back(s);
  endtask

  task automatic clear_counts();
    cnt_rf = 0; cnt_pc = 0; cnt_ir = 0; cnt_dreq = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: called just after a posedge; applies inputs, samples at negedge,
  // checks the state against the expected trace, returns after next posedge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic ir, input logic dr, input logic br);
    logic [2:0] e;
    imem_ready = ir;
    dmem_ready = dr;
    br_taken   = br;
    @(negedge clk);
    s_imem_req = imem_req;  s_dmem_req = dmem_req;  s_dmem_we = dmem_we;
    s_ir_we = ir_we;        s_pc_we = pc_we;        s_pc_sel = pc_sel;
    s_imm_sel = imm_sel;    s_alu_src_a = alu_src_a; s_alu_src_b = alu_src_b;
    s_alu_op = alu_op;      s_rf_we = rf_we;        s_wb_sel = wb_sel;
    s_illegal = illegal;
    s_all = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, imm_sel,
             alu_src_a, alu_src_b, alu_op, rf_we, wb_sel, illegal, state_o};
    s_nh_imem_req = nh_imem_req; s_nh_ir_we = nh_ir_we; s_nh_pc_we = nh_pc_we;
    s_nh_pc_sel = nh_pc_sel;     s_nh_illegal = nh_illegal; s_nh_state = nh_state_o;
    cnt_rf   += int'(rf_we);
    cnt_pc   += int'(pc_we);
    cnt_ir   += int'(ir_we);
    cnt_dreq += int'(dmem_req);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("state", {29'd0, state_o}, {29'd0, e});
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  initial begin
    clear_counts();

    // ---- reset: every output is zero while rst_n is low
    cur = "reset";
    @(posedge clk); #1;
    exp_push(S_FETCH);
    step(1'b1, 1'b1, 1'b1);
    check("all_outputs", {10'd0, s_all}, 32'd0);
    rst_n = 1'b1;

    // ---- ADDI x1,x0,5 zero-wait: F D E WB
    cur = "addi"; clear_counts();
    instr_in = 32'h00500093;
    exp_push(S_FETCH); exp_push(S_DECODE); exp_push(S_EXEC); exp_push(S_WB);
    step(1'b1, 1'b0, 1'b0);
    check("fetch_imem_req", s_imem_req, 1);
    check("fetch_ir_we", s_ir_we, 1);
    check("fetch_imm_sel", s_imm_sel, 3'b000);
    step(1'b0, 1'b0, 1'b0);
    check("decode_imm_sel", s_imm_sel, 3'b001);
    check("decode_pc_we", s_pc_we, 0);
    step(1'b0, 1'b0, 1'b0);
    check("exec_alu_op", s_alu_op, 2'b01);
    check("exec_src_b", s_alu_src_b, 1);
    check("exec_rf_we", s_rf_we, 0);
    step(1'b0, 1'b0, 1'b0);
    check("wb_rf_we", s_rf_we, 1);
    check("wb_pc_we", s_pc_we, 1);
    check("wb_wb_sel", s_wb_sel, 2'b00);
    check("rf_we_cycles", cnt_rf, 1);
    check("pc_we_cycles", cnt_pc, 1);
    check("ir_we_cycles", cnt_ir, 1);

    // ---- LW x1,0(x2) with dmem_ready 3 cycles late: 8 cycles
    cur = "lw"; clear_counts();
    instr_in = 32'h00012083;
    exp_push(S_FETCH); exp_push(S_DECODE); exp_push(S_EXEC);
    exp_push(S_MEM); exp_push(S_MEM); exp_push(S_MEM); exp_push(S_MEM);
    exp_push(S_WB);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);   // dmem_ready outside MEM is ignored
    step(1'b0, 1'b0, 1'b0);
    check("exec_src_b", s_alu_src_b, 1);
    check("exec_alu_op", s_alu_op, 2'b00);
    step(1'b0, 1'b0, 1'b0);
    check("mem_dmem_we", s_dmem_we, 0);
    check("mem_imm_sel", s_imm_sel, 3'b001);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("mem_exit_pc_we", s_pc_we, 0);
    step(1'b0, 1'b0, 1'b0);
    check("wb_wb_sel", s_wb_sel, 2'b01);
    check("dmem_req_cycles", cnt_dreq, 4);
    check("rf_we_cycles", cnt_rf, 1);
    check("pc_we_cycles", cnt_pc, 1);

    // ---- SW x1,0(x2) with one fetch wait: 5 cycles
    cur = "sw"; clear_counts();
    instr_in = 32'h00112023;
    exp_push(S_FETCH); exp_push(S_FETCH); exp_push(S_DECODE);
    exp_push(S_EXEC); exp_push(S_MEM);
    step(1'b0, 1'b0, 1'b0);
    check("wait_ir_we", s_ir_we, 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("decode_imm_sel", s_imm_sel, 3'b010);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("mem_dmem_we", s_dmem_we, 1);
    check("mem_pc_we", s_pc_we, 1);
    check("mem_pc_sel", s_pc_sel, 2'b00);
    check("rf_we_cycles", cnt_rf, 0);
    check("ir_we_cycles", cnt_ir, 1);

    // ---- BEQ x0,x0,8 taken then not taken: 3 cycles each
    for (int t = 1; t >= 0; t--) begin
      cur = (t == 1) ? "beq_taken" : "beq_not_taken"; clear_counts();
      instr_in = 32'h00000463;
      exp_push(S_FETCH); exp_push(S_DECODE); exp_push(S_EXEC);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("decode_src_a", s_alu_src_a, 1);
      check("decode_src_b", s_alu_src_b, 1);
      step(1'b0, 1'b0, t[0]);
      check("exec_imm_sel", s_imm_sel, 3'b011);
      check("exec_alu_op", s_alu_op, 2'b10);
      check("exec_pc_we", s_pc_we, 1);
      check("exec_pc_sel", s_pc_sel, (t == 1) ? 2'b01 : 2'b00);
      check("rf_we_cycles", cnt_rf, 0);
    end

    // ---- JALR x1,0(x2)
    cur = "jalr"; clear_counts();
    instr_in = 32'h000100E7;
    exp_push(S_FETCH); exp_push(S_DECODE); exp_push(S_EXEC); exp_push(S_WB);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("exec_src_a", s_alu_src_a, 0);
    check("exec_src_b", s_alu_src_b, 1);
    check("exec_imm_sel", s_imm_sel, 3'b001);
    step(1'b0, 1'b0, 1'b0);
    check("wb_wb_sel", s_wb_sel, 2'b10);
    check("wb_pc_sel", s_pc_sel, 2'b10);
    check("wb_rf_we", s_rf_we, 1);

    // ---- JAL x1,0
    cur = "jal"; clear_counts();
    instr_in = 32'h000000EF;
    exp_push(S_FETCH); exp_push(S_DECODE); exp_push(S_EXEC); exp_push(S_WB);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("exec_src_a", s_alu_src_a, 1);
    step(1'b0, 1'b0, 1'b0);
    check("wb_imm_sel", s_imm_sel, 3'b101);
    check("wb_pc_sel", s_pc_sel, 2'b01);
    check("wb_wb_sel", s_wb_sel, 2'b10);

    // ---- LUI x1,0x12345
    cur = "lui"; clear_counts();
    instr_in = 32'h123450B7;
    exp_push(S_FETCH); exp_push(S_DECODE); exp_push(S_EXEC); exp_push(S_WB);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("wb_imm_sel", s_imm_sel, 3'b100);
    check("wb_wb_sel", s_wb_sel, 2'b11);
    check("wb_pc_sel", s_pc_sel, 2'b00);

    // ---- FENCE (NOP path): 3 cycles, PC+4 in EXEC
    cur = "fence"; clear_counts();
    instr_in = 32'h0000000F;
    exp_push(S_FETCH); exp_push(S_DECODE); exp_push(S_EXEC);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("exec_pc_we", s_pc_we, 1);
    check("exec_pc_sel", s_pc_sel, 2'b00);
    check("rf_we_cycles", cnt_rf, 0);

    // ---- reset during a MEM wait
    cur = "rst_mem"; clear_counts();
    instr_in = 32'h00012083;
    exp_push(S_FETCH); exp_push(S_DECODE); exp_push(S_EXEC); exp_push(S_MEM);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("mem_dmem_req", s_dmem_req, 1);
    rst_n = 1'b0;
    exp_push(S_FETCH);
    step(1'b0, 1'b1, 1'b0);
    check("rst_dmem_req", s_dmem_req, 0);
    check("rst_rf_we", s_rf_we, 0);
    check("rst_pc_we", s_pc_we, 0);
    rst_n = 1'b1;
    exp_push(S_FETCH);
    step(1'b0, 1'b0, 1'b0);
    check("after_rst_imem_req", s_imem_req, 1);
    check("rf_we_cycles", cnt_rf, 0);
    check("pc_we_cycles", cnt_pc, 0);

    // ---- illegal opcode 0x7F: halt vs. skip
    cur = "illegal"; clear_counts();
    instr_in = 32'h0000007F;
    exp_push(S_FETCH); exp_push(S_DECODE); exp_push(S_HALT); exp_push(S_HALT);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("decode_imm_sel", s_imm_sel, 3'b000);
    check("halt_decode_pc_we", s_pc_we, 0);
    check("nohalt_decode_pc_we", s_nh_pc_we, 1);
    check("nohalt_decode_pc_sel", s_nh_pc_sel, 2'b00);
    step(1'b0, 1'b0, 1'b0);
    check("halt_illegal", s_illegal, 1);
    check("halt_imem_req", s_imem_req, 0);
    check("nohalt_state", s_nh_state, S_FETCH);
    check("nohalt_imem_req", s_nh_imem_req, 1);
    check("nohalt_illegal", s_nh_illegal, 1);
    step(1'b1, 1'b1, 1'b0);
    check("halt_imem_req_2", s_imem_req, 0);
    check("halt_ir_we", s_ir_we, 0);
    check("halt_dmem_req", s_dmem_req, 0);
    check("nohalt_ir_we", s_nh_ir_we, 1);
    check("pc_we_cycles", cnt_pc, 0);

    // ---- reset leaves HALT and clears illegal
    cur = "rst_halt";
    rst_n = 1'b0;
    exp_push(S_FETCH);
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    exp_push(S_FETCH);
    step(1'b0, 1'b0, 1'b0);
    check("illegal_cleared", s_illegal, 0);
    check("imem_req", s_imem_req, 1);

    cur = "end";
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
